reg_readback_ser: RTL and testbench
===================================

Name: reg_readback_ser

Overview:
Serial read-back engine for a bank of parallel registers. The bank is built from the team's clock-enabled, async-clear register primitives.
- On a start request it selects one W-bit word from a flattened register bank by address.
- It snapshots the word, then shifts it out MSB-first on a single data line, qualified by a frame strobe.
- It is the reader counterpart of the register write path. It feeds the debug/slow-control serial link.

Parameters:
W, 16, width of each bank register and of the serial frame (W >= 2)
N, 8, number of registers in the bank (N >= 1)
AW, 3, address width; must satisfy 2**AW >= N

Ports:
clk  in  1  system clock; all state changes on rising edge
clrn  in  1  reset, asynchronous, active-low; clears all state when low
ena  in  1  clock enable; state advances only on edges where ena=1
start  in  1  read request; sampled only in IDLE with ena=1
addr  in  AW  register index; sampled together with start
bank  in  N*W  flattened register bank; register i occupies bits [i*W+W-1 : i*W]
sdo  out  1  serial data, MSB first
sfrm  out  1  frame strobe; high exactly while sdo carries valid data bits
busy  out  1  high from request acceptance until return to IDLE
done  out  1  one-state pulse at end of frame
err  out  1  one-state pulse on request with addr >= N

Behaviour:
- Reset (clrn=0, asynchronous, any state):
  - state=IDLE; shift register, address latch and bit counter all 0.
  - sdo=0, sfrm=0, busy=0, done=0, err=0.
  - Reset mid-frame aborts the frame; no done is produced.
- ena=0 freezes every register; outputs hold their current values. Pulses (done, err) therefore last one ena-qualified cycle, not one clk cycle.
- States: IDLE, LOAD, SHIFT, DONE, all registered. Outputs are decoded from registered state only; no combinational path from inputs to outputs.
- IDLE:
  - busy=0, sfrm=0, sdo=0.
  - start=1 with addr<N: latch addr, go to LOAD.
  - start=1 with addr>=N: err=1 for the next ena cycle; remain IDLE.
- LOAD:
  - busy=1.
  - Shift register <= bank word at latched addr; counter <= W-1.
  - Go to SHIFT.
  - bank is sampled only here; later bank changes do not affect the frame in flight.
- SHIFT:
  - busy=1, sfrm=1, sdo = shift register MSB.
  - Each ena edge: shift left by 1 with 0 fill, counter decrements.
  - Counter==0: go to DONE. Exactly W SHIFT cycles.
- DONE:
  - busy=1, done=1, sfrm=0, sdo=0.
  - Go to IDLE.
- Latency, with ena held 1 and start accepted at edge k:
  - busy=1 from k+1.
  - sfrm=1 for cycles k+2 .. k+W+1.
  - done=1 in cycle k+W+2.
  - busy=0 from k+W+3.
- start while busy=1 (including during the done cycle) is ignored and not queued. Back-to-back frames are therefore separated by at least one IDLE cycle.
- Address indexing uses the latched addr, so addr may change after acceptance.
- Counter width is clog2(W). There is no wrap past 0 because the state leaves SHIFT.

Test Plan:
1. W=16, N=8, bank[3]=16'hA5C3, start with addr=3 at edge k, ena=1 -> busy rises at k+1; sfrm high 16 cycles; sdo=1010010111000011; done at k+18; busy low at k+19.
2. Boundary addresses: addr=0 with bank[0]=16'h8001, then addr=7 with bank[7]=16'hFFFF -> sdo streams 1000000000000001 and 16 ones; no err.
3. N=6, AW=3, start with addr=6 -> err=1 for one cycle, busy stays 0, sfrm stays 0; immediately following start with addr=5 is accepted normally.
4. ena toggling 1,0,1,0 during SHIFT with word 16'h00FF -> each bit held for 2 clk cycles; sequence still 0000000011111111; done held while ena=0.
5. clrn pulsed low at 5th SHIFT cycle -> sdo, sfrm, busy drop immediately; no done; next start after release yields a full, correct frame.
6. start pulsed every cycle during a frame, and bank[3] changed to 16'h1234 mid-frame -> only one frame emitted, and it carries the original 16'hA5C3; next request after return to IDLE reads 16'h1234.

Source files
------------

// File: rtl/reg_readback_ser.sv
// Serial read-back engine: snapshots one word of a flattened register bank by address
// and shifts it out MSB-first on sdo, qualified by the sfrm frame strobe.
module reg_readback_ser #(
  parameter int unsigned W  = 16,
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 3
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            ena,
  input  logic            start,
  input  logic [AW-1:0]   addr,
  input  logic [N*W-1:0]  bank,
  output logic            sdo,
  output logic            sfrm,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            err_q, err_d;
  logic [W-1:0]    word_sel;
  logic            addr_ok;

  assign addr_ok = (32'(addr) < N);

  // Index with the latched address so addr may move once a request is accepted.
  always_comb begin
    word_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(addr_q) == i) word_sel = bank[i*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (addr_ok) begin
            addr_d  = addr;
            state_d = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        shreg_d = word_sel;
        cnt_d   = CW'(W - 1);
        state_d = StShift;
      end
      StShift: begin
        shreg_d = {shreg_q[W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign sfrm = (state_q == StShift);
  assign sdo  = sfrm & shreg_q[W-1];
  assign done = (state_q == StDone);
  assign err  = err_q;

endmodule

// File: tb/tb_reg_readback_ser.sv
// Directed bench for reg_readback_ser: an N=8 instance for framing/timing and an N=6
// instance for out-of-range address handling.
module tb_reg_readback_ser;

  logic          clk;
  logic          clrn;
  logic          ena;
  logic          start, start6;
  logic [2:0]    addr, addr6;
  logic [127:0]  bank;
  logic [95:0]   bank6;
  logic          sdo, sfrm, busy, done, err;
  logic          sdo6, sfrm6, busy6, done6, err6;

  int checks;
  int errors;

  reg_readback_ser #(.W(16), .N(8), .AW(3)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .ena   (ena),
    .start (start),
    .addr  (addr),
    .bank  (bank),
    .sdo   (sdo),
    .sfrm  (sfrm),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  reg_readback_ser #(.W(16), .N(6), .AW(3)) dut6 (
    .clk   (clk),
    .clrn  (clrn),
    .ena   (ena),
    .start (start6),
    .addr  (addr6),
    .bank  (bank6),
    .sdo   (sdo6),
    .sfrm  (sfrm6),
    .busy  (busy6),
    .done  (done6),
    .err   (err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request on the N=8 instance with ena=1 and records the frame.
  // Cycle index 1 is the cycle right after the accepting edge.
  task automatic capture(input logic [2:0] a, output logic [15:0] word, output int nsfrm,
                         output int busy_idx, output int done_idx, output int idle_idx,
                         output bit err_seen);
    word = '0; nsfrm = 0; busy_idx = -1; done_idx = -1; idle_idx = -1; err_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    addr  = a;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (err) err_seen = 1'b1;
      if (busy && busy_idx < 0) busy_idx = i;
      if (sfrm) begin
        word = {word[14:0], sdo};
        nsfrm++;
      end
      if (done && done_idx < 0) done_idx = i;
      if (!busy && busy_idx >= 0) begin
        idle_idx = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({sdo, sfrm, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b want 00000", {sdo, sfrm, busy, done, err});
    end
    checks++;
    if ({sdo6, sfrm6, busy6, done6, err6} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs6: got %b want 00000", {sdo6, sfrm6, busy6, done6, err6});
    end
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    checks++;
    if ({sfrm, busy, done, err} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 0000", {sfrm, busy, done, err});
    end
  endtask

  task automatic test_basic_frame();
    logic [15:0] w; int n, bi, di, ii; bit es;
    capture(3'd3, w, n, bi, di, ii, es);
    checks++;
    if (bi !== 1) begin errors++; $display("FAIL basic_busy_rise: got %0d want 1", bi); end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL basic_sfrm_len: got %0d want 16", n); end
    checks++;
    if (w !== 16'hA5C3) begin errors++; $display("FAIL basic_word: got %h want a5c3", w); end
    checks++;
    if (di !== 18) begin errors++; $display("FAIL basic_done_idx: got %0d want 18", di); end
    checks++;
    if (ii !== 19) begin errors++; $display("FAIL basic_idle_idx: got %0d want 19", ii); end
  endtask

  task automatic test_boundary_addr();
    logic [15:0] w; int n, bi, di, ii; bit es;
    capture(3'd0, w, n, bi, di, ii, es);
    checks++;
    if (w !== 16'h8001) begin errors++; $display("FAIL addr0_word: got %h want 8001", w); end
    checks++;
    if (es !== 1'b0) begin errors++; $display("FAIL addr0_err: got %b want 0", es); end
    capture(3'd7, w, n, bi, di, ii, es);
    checks++;
    if (w !== 16'hFFFF || n !== 16) begin
      errors++;
      $display("FAIL addr7_word: got %h/%0d want ffff/16", w, n);
    end
    checks++;
    if (es !== 1'b0) begin errors++; $display("FAIL addr7_err: got %b want 0", es); end
  endtask

  task automatic test_addr_error();
    logic [15:0] w; int n;
    @(negedge clk);
    start6 = 1'b1;
    addr6  = 3'd6;
    @(negedge clk);
    checks++;
    if ({err6, busy6, sfrm6} !== 3'b100) begin
      errors++;
      $display("FAIL err_pulse: got err/busy/sfrm %b want 100", {err6, busy6, sfrm6});
    end
    addr6 = 3'd5;
    @(negedge clk);
    start6 = 1'b0;
    checks++;
    if ({err6, busy6} !== 2'b01) begin
      errors++;
      $display("FAIL err_then_accept: got err/busy %b want 01", {err6, busy6});
    end
    w = '0; n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sfrm6) begin w = {w[14:0], sdo6}; n++; end
      if (!busy6) break;
    end
    checks++;
    if (w !== 16'h5A5A || n !== 16 || busy6 !== 1'b0) begin
      errors++;
      $display("FAIL n6_addr5_frame: got %h/%0d busy %b want 5a5a/16 busy 0", w, n, busy6);
    end
  endtask

  task automatic test_ena_toggle();
    logic [31:0] rec; int nsf, ndone;
    rec = '0; nsf = 0; ndone = 0;
    @(negedge clk);
    start = 1'b1;
    addr  = 3'd2;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (sfrm) begin rec = {rec[30:0], sdo}; nsf++; end
      if (done) ndone++;
      if (!busy && i > 1) break;
      ena = ~ena;
    end
    ena = 1'b1;
    checks++;
    if (nsf !== 32) begin errors++; $display("FAIL ena_sfrm_len: got %0d want 32", nsf); end
    checks++;
    if (rec !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL ena_bits: got %h want 0000ffff", rec);
    end
    checks++;
    if (ndone !== 2) begin errors++; $display("FAIL ena_done_len: got %0d want 2", ndone); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w; int n, bi, di, ii, nsf; bit es, done_seen;
    nsf = 0; done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    addr  = 3'd3;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (sfrm) nsf++;
      if (nsf == 5) break;
    end
    #2 clrn = 1'b0;
    #1;
    checks++;
    if ({sdo, sfrm, busy} !== 3'b000 || nsf !== 5) begin
      errors++;
      $display("FAIL midframe_clear: got sdo/sfrm/busy %b after %0d bits want 000 after 5",
               {sdo, sfrm, busy}, nsf);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    clrn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL midframe_no_done: got activity %b want 0", done_seen);
    end
    capture(3'd3, w, n, bi, di, ii, es);
    checks++;
    if (w !== 16'hA5C3 || ii !== 19) begin
      errors++;
      $display("FAIL after_reset_frame: got %h idle %0d want a5c3 idle 19", w, ii);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w, w2; int nsf, ndone, n, bi, di, ii; bit es;
    w = '0; nsf = 0; ndone = 0;
    @(negedge clk);
    start = 1'b1;
    addr  = 3'd3;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sfrm) begin w = {w[14:0], sdo}; nsf++; end
      if (i == 4) addr = 3'd0;
      if (i == 8) bank[3*16 +: 16] = 16'h1234;
      if (done) begin
        ndone++;
        start = 1'b0;
        break;
      end
    end
    checks++;
    if (w !== 16'hA5C3 || nsf !== 16) begin
      errors++;
      $display("FAIL b2b_snapshot: got %h/%0d want a5c3/16", w, nsf);
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL b2b_done: got %0d want 1", ndone); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got busy %b want 0", busy);
    end
    capture(3'd3, w2, n, bi, di, ii, es);
    checks++;
    if (w2 !== 16'h1234) begin errors++; $display("FAIL b2b_new_word: got %h want 1234", w2); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clrn   = 1'b0;
    ena    = 1'b1;
    start  = 1'b0;
    start6 = 1'b0;
    addr   = '0;
    addr6  = '0;
    bank   = '0;
    bank6  = '0;
    bank[0*16 +: 16]  = 16'h8001;
    bank[2*16 +: 16]  = 16'h00FF;
    bank[3*16 +: 16]  = 16'hA5C3;
    bank[7*16 +: 16]  = 16'hFFFF;
    bank6[5*16 +: 16] = 16'h5A5A;

    test_reset();
    test_basic_frame();
    test_boundary_addr();
    test_addr_error();
    test_ena_toggle();
    test_reset_midframe();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
